// File: rtl/hdmi_pkg.sv
// Shared constants and write-FSM encoding for the HDMI line scaler.
package hdmi_pkg;

  localparam int unsigned H_ACT     = 640;
  localparam int unsigned V_ACT     = 480;
  localparam int unsigned DEF_SRC_W = 256;
  localparam int unsigned DEF_SRC_H = 240;
  localparam int unsigned DEF_X_OFF = 64;
  localparam int unsigned RGB_W     = 16;

  // Renderer handshake state: request issued, then fill until line_done.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StFill = 2'd2
  } wr_state_e;

endpackage

// File: rtl/hdmi_line_ram.sv
// Simple dual-port line RAM: one write port, one registered read port.
module hdmi_line_ram #(
  parameter int unsigned AddrW = 9,
  parameter int unsigned DataW = 16
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << AddrW;

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rdata_q;

  // Write port and registered read; no reset, contents undefined after power-up.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/hdmi_line_scaler.sv
// 2x line scaler: ping-pong source line buffers feeding a centred 512x480 window.
module hdmi_line_scaler
  import hdmi_pkg::*;
#(
  parameter int unsigned         X_OFF        = DEF_X_OFF,
  parameter int unsigned         SRC_W        = DEF_SRC_W,
  parameter int unsigned         SRC_H        = DEF_SRC_H,
  parameter logic [RGB_W-1:0]    BORDER_COLOR = 16'h0000
) (
  input  logic             hdmi_clk,
  input  logic             rstn,
  input  logic [11:0]      pixel_xpos,
  input  logic [11:0]      pixel_ypos,
  output logic [RGB_W-1:0] rd_data,
  output logic             IsGameWindow,
  output logic             line_req,
  output logic [7:0]       line_num,
  input  logic             wr_en,
  input  logic [7:0]       wr_addr,
  input  logic [RGB_W-1:0] wr_data,
  input  logic             line_done,
  output logic             underrun,
  output logic [7:0]       underrun_cnt
);

  localparam logic [11:0] XFirst = 12'(X_OFF);
  localparam logic [11:0] XLast  = 12'(X_OFF + 2 * SRC_W - 1);
  localparam logic [11:0] YEnd   = 12'(2 * SRC_H);
  localparam logic [11:0] SrcH12 = 12'(SRC_H);

  logic        in_win;
  logic        swap;
  logic        done_ok;
  logic [11:0] x_rel;
  logic [7:0]  src_x;
  logic [11:0] y_next;
  logic [7:0]  line_next;

  wr_state_e   state_q, state_d;
  logic        front_q, front_d;
  logic        front_valid_q, front_valid_d;
  logic        back_valid_q, back_valid_d;
  logic        show_q, show_d;
  logic        in_win_q;
  logic        line_req_q, line_req_d;
  logic [7:0]  line_num_q, line_num_d;
  logic        underrun_q, underrun_d;
  logic [7:0]  underrun_cnt_q, underrun_cnt_d;

  logic             ram_we;
  logic [8:0]       ram_waddr;
  logic [8:0]       ram_raddr;
  logic [RGB_W-1:0] ram_rdata;

  // Window test, source address and swap detection for the requested pixel.
  always_comb begin
    in_win    = (pixel_xpos >= XFirst) && (pixel_xpos <= XLast) && (pixel_ypos < YEnd);
    x_rel     = pixel_xpos - XFirst;
    src_x     = x_rel[8:1];
    swap      = (pixel_xpos == XLast) && pixel_ypos[0] && (pixel_ypos < YEnd);
    y_next    = (pixel_ypos + 12'd1) >> 1;
    // y_next never exceeds SRC_H, so wrapping to 0 is the whole modulo.
    line_next = (y_next >= SrcH12) ? 8'd0 : y_next[7:0];
    done_ok   = (state_q == StFill) && line_done;
  end

  // Writes only land during FILL and always target the bank not on display.
  assign ram_we    = (state_q == StFill) && wr_en;
  assign ram_waddr = {~front_q, wr_addr};
  assign ram_raddr = {front_q, src_x};

  hdmi_line_ram #(
    .AddrW (9),
    .DataW (RGB_W)
  ) u_line_ram (
    .clk_i   (hdmi_clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (wr_data),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Next-state: bank swap, renderer handshake and underrun accounting.
  always_comb begin
    state_d        = state_q;
    front_d        = front_q;
    front_valid_d  = front_valid_q;
    back_valid_d   = back_valid_q;
    line_req_d     = 1'b0;
    line_num_d     = line_num_q;
    underrun_d     = underrun_q;
    underrun_cnt_d = underrun_cnt_q;
    // Valid qualifier travels with the read so it matches the bank actually read.
    show_d         = in_win && front_valid_q;

    if (swap) begin
      front_d       = ~front_q;
      // A line_done coinciding with the swap still counts as a finished line.
      front_valid_d = back_valid_q | done_ok;
      back_valid_d  = 1'b0;
      state_d       = StReq;
      line_req_d    = 1'b1;
      line_num_d    = line_next;
      if ((state_q == StFill) && !line_done) begin
        underrun_d = 1'b1;
        if (underrun_cnt_q != 8'hFF) begin
          underrun_cnt_d = underrun_cnt_q + 8'd1;
        end
      end
    end else begin
      case (state_q)
        StReq: begin
          state_d      = StFill;
          back_valid_d = 1'b0;
        end
        StFill: begin
          if (line_done) begin
            state_d      = StIdle;
            back_valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // All state in one register bank with asynchronous active-low reset.
  always_ff @(posedge hdmi_clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= StIdle;
      front_q        <= 1'b0;
      front_valid_q  <= 1'b0;
      back_valid_q   <= 1'b0;
      show_q         <= 1'b0;
      in_win_q       <= 1'b0;
      line_req_q     <= 1'b0;
      line_num_q     <= 8'd0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= 8'd0;
    end else begin
      state_q        <= state_d;
      front_q        <= front_d;
      front_valid_q  <= front_valid_d;
      back_valid_q   <= back_valid_d;
      show_q         <= show_d;
      in_win_q       <= in_win;
      line_req_q     <= line_req_d;
      line_num_q     <= line_num_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign rd_data      = show_q ? ram_rdata : BORDER_COLOR;
  assign IsGameWindow = in_win_q;
  assign line_req     = line_req_q;
  assign line_num     = line_num_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_hdmi_line_scaler.sv
// Self-checking bench for hdmi_line_scaler with a line-level reference model.
module tb_hdmi_line_scaler;

  localparam int          X_OFF  = 64;
  localparam int          SW     = 256;
  localparam int          SH     = 240;
  localparam int          X_LAST = X_OFF + 2 * SW - 1;
  localparam logic [15:0] BORDER = 16'h0000;

  logic        hdmi_clk = 1'b0;
  logic        rstn = 1'b0;
  logic [11:0] pixel_xpos = '0;
  logic [11:0] pixel_ypos = '0;
  logic [15:0] rd_data;
  logic        IsGameWindow;
  logic        line_req;
  logic [7:0]  line_num;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        line_done = 1'b0;
  logic        underrun;
  logic [7:0]  underrun_cnt;

  hdmi_line_scaler dut (
    .hdmi_clk     (hdmi_clk),
    .rstn         (rstn),
    .pixel_xpos   (pixel_xpos),
    .pixel_ypos   (pixel_ypos),
    .rd_data      (rd_data),
    .IsGameWindow (IsGameWindow),
    .line_req     (line_req),
    .line_num     (line_num),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .line_done    (line_done),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 hdmi_clk = ~hdmi_clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] seed;

  // Reference model: which source line each buffer role holds (-1 = nothing valid).
  int  front_line, back_line, pend_line;
  int  fa, fb, ba, bb, pa, pb;
  bit  active;
  bit  uflag;
  int  uc;
  int  nreq_seen;

  // Expected outputs for the pixel presented on the previous step.
  bit          have_exp;
  logic [15:0] exp_d;
  bit          exp_w;
  bit          exp_req;

  // Renderer behaviour: 0 normal, 1 withhold line_done, 2 line_done on the swap cycle.
  int r_state, r_idx, r_line, r_mode, next_mode;

  function automatic logic [15:0] pix(input int l, input int x);
    logic [15:0] v;
    v = {8'(l), 8'(x)};
    return v ^ seed;
  endfunction

  function automatic int wa(input int i);
    if (i == 0) return 0;
    if (i == 1) return pa;
    if (i == 2) return pb;
    return 255;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    front_line = -1; back_line = -1; pend_line = -1;
    fa = 1; fb = 200; ba = 1; bb = 200; pa = 1; pb = 200;
    active = 0; uflag = 0; uc = 0;
    have_exp = 0; exp_req = 0;
    r_state = 0; r_idx = 0; r_line = 0; r_mode = 0;
  endtask

  task automatic do_reset();
    @(negedge hdmi_clk);
    rstn = 1'b0; wr_en = 1'b0; line_done = 1'b0;
    #1;
    chk("rst_rd_data", 32'(rd_data), 32'(16'h0000));
    chk("rst_win", 32'(IsGameWindow), 32'd0);
    chk("rst_line_req", 32'(line_req), 32'd0);
    chk("rst_line_num", 32'(line_num), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_underrun_cnt", 32'(underrun_cnt), 32'd0);
    repeat (2) @(negedge hdmi_clk);
    rstn = 1'b1;
    model_reset();
  endtask

  // One pixel clock: check the previous pixel, play renderer, present (x, y).
  task automatic step(input int x, input int y);
    bit sw, done_now, win;
    @(negedge hdmi_clk);
    if (have_exp) begin
      chk("rd_data", 32'(rd_data), 32'(exp_d));
      chk("IsGameWindow", 32'(IsGameWindow), 32'(exp_w));
    end
    chk("line_req", 32'(line_req), 32'(exp_req));
    chk("underrun", 32'(underrun), 32'(uflag));
    chk("underrun_cnt", 32'(underrun_cnt), 32'(uc));
    if (line_req) begin
      chk("line_num", 32'(line_num), 32'(pend_line));
      nreq_seen++;
      r_line  = int'(line_num);
      pa      = $urandom_range(1, 127);
      pb      = $urandom_range(128, 254);
      r_mode  = next_mode;
      r_state = 1;
      r_idx   = 0;
    end
    pixel_xpos = 12'(x);
    pixel_ypos = 12'(y);
    wr_en      = 1'b0;
    line_done  = 1'b0;
    sw = (x == X_LAST) && (y % 2 == 1) && (y < 2 * SH);
    case (r_state)
      1: r_state = 2;  // DUT is in its request cycle; writes would be ignored
      2: begin
        wr_en   = 1'b1;
        wr_addr = 8'(wa(r_idx));
        wr_data = pix(r_line, wa(r_idx));
        r_idx++;
        if (r_idx == 4) r_state = (r_mode == 0) ? 5 : ((r_mode == 2) ? 3 : 4);
      end
      3: if (sw) begin line_done = 1'b1; r_state = 0; end
      5: begin line_done = 1'b1; r_state = 0; end
      default: ;
    endcase
    win   = (x >= X_OFF) && (x <= X_LAST) && (y < 2 * SH);
    exp_w = win;
    exp_d = (win && front_line >= 0) ? pix(front_line, (x - X_OFF) / 2) : BORDER;
    done_now = line_done && active;
    if (sw) begin
      if (active && done_now) begin
        front_line = pend_line; fa = pa; fb = pb;
      end else if (active) begin
        front_line = -1;
        uflag = 1;
        if (uc < 255) uc++;
      end else begin
        front_line = back_line; fa = ba; fb = bb;
      end
      back_line = -1;
      active    = 1;
      pend_line = ((y + 1) / 2) % SH;
    end else if (done_now) begin
      back_line = pend_line; ba = pa; bb = pb;
      active    = 0;
    end
    exp_req  = sw;
    have_exp = 1;
  endtask

  // Sparse row scan: borders, window edges, the written source pixels, the swap column.
  task automatic row(input int y);
    int xs[12];
    xs = '{0, 63, 64, 65, 64 + 2 * fa, 65 + 2 * fa, 64 + 2 * fb, 65 + 2 * fb,
           574, 575, 576, 639};
    for (int i = 0; i < 12; i++) step(xs[i], y);
  endtask

  task automatic frame(input int y0, input int y1, input int kind);
    int r;
    for (int y = y0; y <= y1; y++) begin
      if (y % 2 == 1) begin
        r = $urandom_range(0, 15);
        case (kind)
          1: begin
            if (y == 9 || y == 41 || y == 43 || r == 0) next_mode = 1;
            else if (y == 21 || r == 1) next_mode = 2;
            else next_mode = 0;
          end
          2: next_mode = 1;
          default: next_mode = 0;
        endcase
      end
      row(y);
    end
  endtask

  initial begin
    seed      = 16'($urandom);
    nreq_seen = 0;
    next_mode = 0;
    model_reset();
    do_reset();

    // Row 0 full sweep: border everywhere, window flag only on 64..575.
    for (int x = 0; x < 640; x++) step(x, 0);

    // First frame with an ideal renderer, plus two rows below the window.
    frame(1, 481, 0);
    step(700, 481);
    chk("req_count_frame1", 32'(nreq_seen), 32'd240);

    // Second frame: random renderer timing with forced underruns and late dones.
    frame(0, 479, 1);

    // Renderer never finishes: the counter must saturate.
    frame(0, 479, 2);
    frame(0, 59, 2);
    step(700, 60);
    chk("underrun_cnt_sat", 32'(underrun_cnt), 32'd255);

    // Reset in the middle of a fill, then recover.
    next_mode = 0;
    frame(0, 28, 0);
    next_mode = 1;
    row(29);
    step(0, 30);
    step(63, 30);
    step(64, 30);
    step(65, 30);
    step(100, 30);
    do_reset();
    frame(31, 39, 0);
    step(700, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
